uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver and counterpart of the fixed-data transmitter path. It reconstructs 8N1 frames from the serial `rx` line using a 16x oversampling tick from the shared baud tick generator. Each received byte is presented on `rx_data` with a single-cycle `rx_done` strobe. It sits between the board RX pin and downstream consumers such as an echo/loopback controller or a display FSM.

Parameters:
OVERSAMPLE, 16, tick pulses per bit period; must be even and at least 8.
DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-high reset.
sample_tick  input  1  one-clk pulse at BAUD*OVERSAMPLE. For 9600 baud at 100 MHz, the generator's BAUD_COUNT is 651.
rx  input  1  raw serial line; asynchronous; idle high.
rx_data  output  DATA_BITS  last received byte; held until the next frame completes.
rx_done  output  1  one-clk pulse when a frame completes, valid or not.
frame_err  output  1  qualifies rx_done: 1 means the stop bit sampled low; held until the next rx_done.
rx_busy  output  1  high whenever the state machine is not in IDLE.

Behaviour:
- Reset: one clock (`clk`); reset is asynchronous and active-high (`rst`). All registers clear immediately on rst=1, regardless of clk.
  - rx_data=0, rx_done=0, frame_err=0, rx_busy=0, state=IDLE.
  - Synchronizer flops reset to 1 (line idle).
- Input sync: rx passes through a 2-FF synchronizer. All decisions use the second stage, rx_s, which adds 2 clk of latency.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits and counts only on sample_tick.
  - bit_cnt is $clog2(DATA_BITS+1) bits.
  - Both clear on every state transition.
- IDLE:
  - On sample_tick with rx_s=0 -> START, tick_cnt=0.
  - rx_s going low between ticks is caught on the next tick.
- START:
  - On sample_tick, when tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0 -> DATA.
    - rx_s=1 -> IDLE (glitch rejected; no rx_done).
  - Otherwise tick_cnt++.
- DATA:
  - On sample_tick, when tick_cnt==OVERSAMPLE-1, shift right: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, bit_cnt++, tick_cnt=0.
  - When bit_cnt reaches DATA_BITS -> STOP.
  - Each sample therefore lands at mid-bit.
- STOP: on sample_tick, when tick_cnt==OVERSAMPLE-1, on the next clk:
  - rx_data <= shreg.
  - frame_err <= ~rx_s.
  - rx_done=1 for exactly one clk.
  - Next state: rx_s=1 -> IDLE; rx_s=0 -> BREAK.
- BREAK: on sample_tick with rx_s=1 -> IDLE. This prevents a held-low line from retriggering frames.
- Latency: rx_done rises (OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1)) ticks after the tick that detected the start bit. That is 152 ticks at the defaults, plus at most 1 clk of output registration.
- Timing rules:
  - sample_tick is ignored outside its one-clk pulse.
  - Nothing advances between ticks.
  - rx_done is never asserted in consecutive clks.
- Back-to-back frames: a start bit immediately after the stop sample is accepted. The return to IDLE happens in the same clk as rx_done, so no idle gap is required.
- Reset mid-frame: the frame is discarded; outputs go to reset values; no rx_done.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3 bits.
  - constants DEF_OVERSAMPLE=16 and DEF_DATA_BITS=8.
  - tick-count helper SYS_CLK/(BAUD*OVERSAMPLE).
- One natural sub-module: sync_2ff, a reusable 2-flop synchronizer with parameterized reset value. It is also used later for button inputs.
- FSM and datapath stay in uart_rx.

Test Plan:
1. Send 8'h30 at 9600 baud (bit = 16 ticks) -> one rx_done pulse; rx_data=8'h30; frame_err=0; rx_busy falls with rx_done; rx_done lands 152 ticks ±1 clk after the start-detect tick.
2. Send a low glitch lasting 4 ticks, then line high -> START then back to IDLE; no rx_done; rx_busy high for 8 ticks only.
3. Send 8'h55 with the stop bit forced low, then hold low for 3 bit times, then release -> rx_done with rx_data=8'h55 and frame_err=1; state BREAK until the line rises; no second rx_done.
4. Send 8'h41 then 8'h5A back-to-back with zero idle bits -> exactly two rx_done pulses, 160 ticks apart; data 8'h41 then 8'h5A; frame_err=0 both.
5. Assert rst for 3 clk midway through DATA of 8'hFF, release, then send 8'hA5 -> no rx_done for 8'hFF; outputs 0 during reset; next rx_done has rx_data=8'hA5.
6. Loopback: transmitter tx wired to rx, trigger the fixed 8'h30 frame 3 times -> 3 rx_done pulses; each rx_data=8'h30; frame_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, defaults and baud helper
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  function automatic int tick_count(input int sys_clk, input int baud, input int oversample);
    return sys_clk / (baud * oversample);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async input through two flops before anyone looks at it
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= {RST_VAL, RST_VAL};
    else     {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, mid-bit sampling and break hold-off
module uart_rx import uart_pkg::*; #(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  rx_state_t state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic ferr_n, done_n, rx_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign rx_busy = state != IDLE;
  // FSM state, counters and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      frame_err <= ferr_n;
      rx_done   <= done_n;
    end
  // next state; everything holds between ticks and counters clear on each transition
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    data_n  = rx_data;
    ferr_n  = frame_err;
    done_n  = 1'b0;
    if (sample_tick)
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
          bit_n   = '0;
        end
        START: if (tick_cnt == MID) begin
          state_n = rx_s ? IDLE : DATA;
          tick_n  = '0;
          bit_n   = '0;
        end else tick_n = tick_cnt + 1'b1;
        DATA: if (tick_cnt == LAST) begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          tick_n  = '0;
          bit_n   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          state_n = (bit_cnt == LAST_BIT) ? STOP : DATA;
        end else tick_n = tick_cnt + 1'b1;
        STOP: if (tick_cnt == LAST) begin
          data_n  = shreg;
          ferr_n  = ~rx_s;
          done_n  = 1'b1;
          state_n = rx_s ? IDLE : BREAK;
          tick_n  = '0;
          bit_n   = '0;
        end else tick_n = tick_cnt + 1'b1;
        BREAK: if (rx_s) begin
          state_n = IDLE;
          tick_n  = '0;
          bit_n   = '0;
        end
        default: begin
          state_n = IDLE;
          tick_n  = '0;
          bit_n   = '0;
        end
      endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames, glitch, break, back-to-back, reset and loopback checks
module tb_uart_rx;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;
  logic clk = 1'b0, rst = 1'b1, sample_tick, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_done, frame_err, rx_busy;
  int tests = 0, failed = 0;
  int tick_num = 0, start_tick = 0;
  int done_cnt = 0, done_tick = 0, prev_tick = 0, consec = 0;
  logic [7:0] last_data = '0, prev_data = '0;
  logic last_ferr = 1'b0, prev_ferr = 1'b0, busy_at_done = 1'b0, prev_done = 1'b0;
  int snap, n;

  uart_rx dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  always @(posedge clk) if (sample_tick) tick_num <= tick_num + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      prev_tick = done_tick;
      done_tick = tick_num;
      prev_data = last_data;
      last_data = rx_data;
      prev_ferr = last_ferr;
      last_ferr = frame_err;
      busy_at_done = rx_busy;
      if (prev_done) consec++;
    end
    prev_done = rx_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!sample_tick);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_tick = tick_num;
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) wait_tick();
    end
    rx = stop;
    repeat (16) wait_tick();
  endtask

  task automatic tx_frame_clk(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT_CLKS) @(posedge clk);
      #3;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", rx_data, 8'h00);
    check("reset_done", rx_done, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_busy", rx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) wait_tick();

    snap = done_cnt;
    send_frame(8'h30, 1'b1);
    repeat (4) wait_tick();
    check("t1_done_cnt", done_cnt - snap, 1);
    check("t1_data", last_data, 8'h30);
    check("t1_ferr", last_ferr, 0);
    check("t1_busy_falls", busy_at_done, 0);
    check("t1_latency", done_tick - start_tick - 1, 152);

    snap = done_cnt;
    rx = 1'b0;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      wait_tick();
      if (i == 4) rx = 1'b1;
      if (rx_busy) n++;
    end
    repeat (20) wait_tick();
    check("t2_busy_ticks", n, 8);
    check("t2_no_done", done_cnt - snap, 0);

    snap = done_cnt;
    send_frame(8'h55, 1'b0);
    repeat (48) wait_tick();
    check("t3_in_break", rx_busy, 1);
    rx = 1'b1;
    repeat (4) wait_tick();
    check("t3_idle", rx_busy, 0);
    check("t3_done_cnt", done_cnt - snap, 1);
    check("t3_data", last_data, 8'h55);
    check("t3_ferr", last_ferr, 1);

    repeat (10) wait_tick();
    snap = done_cnt;
    send_frame(8'h41, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (10) wait_tick();
    check("t4_done_cnt", done_cnt - snap, 2);
    check("t4_spacing", done_tick - prev_tick, 160);
    check("t4_data0", prev_data, 8'h41);
    check("t4_data1", last_data, 8'h5A);
    check("t4_ferr0", prev_ferr, 0);
    check("t4_ferr1", last_ferr, 0);

    snap = done_cnt;
    rx = 1'b0;
    repeat (16) wait_tick();
    rx = 1'b1;
    repeat (48) wait_tick();
    check("t5_busy_pre", rx_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_data", rx_data, 8'h00);
    check("t5_rst_busy", rx_busy, 0);
    check("t5_rst_ferr", frame_err, 0);
    check("t5_rst_done", rx_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) wait_tick();
    check("t5_no_done", done_cnt - snap, 0);
    send_frame(8'hA5, 1'b1);
    repeat (4) wait_tick();
    check("t5_done_cnt", done_cnt - snap, 1);
    check("t5_data", last_data, 8'hA5);

    for (int k = 0; k < 3; k++) begin
      snap = done_cnt;
      repeat (37 + 5 * k) @(posedge clk);
      #3;
      tx_frame_clk(8'h30);
      repeat (10) wait_tick();
      check("t6_done_cnt", done_cnt - snap, 1);
      check("t6_data", last_data, 8'h30);
      check("t6_ferr", last_ferr, 0);
    end

    check("no_consecutive_done", consec, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
